fifo_wr_arbiter: RTL

- Shares one fifo_mem write port between NUM_REQ producers.
- Round-robin arbitration with bounded bursts: one requester owns the write port for up to MAX_BURST beats, then the grant rotates.
- Drives the FIFO's trans_write/data_in directly.
- Monitors full_ind/threshold_ind/overflow_ind so no beat is issued into a full FIFO.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO arbitration blocks.
//   arb_state_e       : arbiter FSM states
//   id_width()        : index width for an N-entry selector (at least 1 bit)
//   DEF_MAX_BURST     : default beats per grant
//   DEF_STALL_TIMEOUT : default idle-valid cycles before a grant is revoked
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE, BURST} arb_state_e;

  localparam int unsigned DEF_MAX_BURST     = 4;
  localparam int unsigned DEF_STALL_TIMEOUT = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches eligible upward from last_grant+1, wrapping, and returns the first set bit.
//   eligible   in  N  candidate mask
//   last_grant in  W  previous winner (search starts just above it)
//   found      out 1  any candidate present
//   idx        out W  winning index (0 when found=0)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = id_width(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_grant,
  output logic         found,
  output logic [W-1:0] idx
);

  int unsigned k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(last_grant) + i) % N;
      if (!found && eligible[k]) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a single fifo_mem write port.
// A granted requester owns the port for up to MAX_BURST beats, until its last beat,
// or until it leaves valid low for STALL_TIMEOUT cycles; then the grant rotates.
// Optional macro FIFO_ARB_THROTTLE_EN: while fifo_threshold_ind is high at arbitration,
// only requesters in PRIO_MASK may win.
//   clk_in, areset_b      clock / async active-low reset
//   req_valid/data/last   per-requester beat interface, req_ready back
//   fifo_*_ind            FIFO status inputs
//   fifo_trans_write/data_in  FIFO write port
//   grant_id, busy, err_overflow  status outputs
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_BURST     = DEF_MAX_BURST,
  parameter int unsigned STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  parameter logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1)
) (
  input  logic                          clk_in,
  input  logic                          areset_b,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full_ind,
  input  logic                          fifo_threshold_ind,
  input  logic                          fifo_overflow_ind,
  output logic                          fifo_trans_write,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_overflow
);

  localparam int unsigned IdW    = id_width(NUM_REQ);
  localparam int unsigned BeatW  = id_width(MAX_BURST);
  localparam int unsigned StallW = id_width(STALL_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [IdW-1:0]     last_grant_q, last_grant_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [StallW-1:0]  stall_q, stall_d;
  logic               err_q;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IdW-1:0]     pick_idx;
  logic               gnt_valid, gnt_last, xfer, burst_exit;

`ifdef FIFO_ARB_THROTTLE_EN
  // Near-full FIFO: only priority requesters may start a new burst.
  assign eligible = fifo_threshold_ind ? (req_valid & PRIO_MASK) : req_valid;
`else
  assign eligible = req_valid;
  logic unused_throttle;
  assign unused_throttle = fifo_threshold_ind ^ (^PRIO_MASK);
`endif

  rr_pick #(
    .N (NUM_REQ),
    .W (IdW)
  ) u_rr_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign gnt_valid    = req_valid[grant_q];
  assign gnt_last     = req_last[grant_q];
  // Not gated in IDLE; consumers qualify it with fifo_trans_write.
  assign fifo_data_in = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id     = grant_q;
  assign busy         = (state_q == BURST);
  assign err_overflow = err_q;

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    beat_d           = beat_q;
    stall_d          = stall_q;
    req_ready        = '0;
    fifo_trans_write = 1'b0;
    xfer             = 1'b0;
    burst_exit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[grant_q] = ~fifo_full_ind;
        xfer               = gnt_valid & ~fifo_full_ind;
        fifo_trans_write   = xfer;
        if (xfer) begin
          stall_d = '0;
          if (gnt_last || (beat_q == BeatW'(MAX_BURST - 1))) burst_exit = 1'b1;
          else beat_d = beat_q + 1'b1;
        end else if (gnt_valid) begin
          stall_d = '0;
        end else if (!fifo_full_ind) begin
          // A full FIFO is not the requester's fault, so the stall counter freezes then.
          if (stall_q == StallW'(STALL_TIMEOUT - 1)) burst_exit = 1'b1;
          else stall_d = stall_q + 1'b1;
        end
        if (burst_exit) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          beat_d       = '0;
          stall_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IdW'(NUM_REQ - 1);
      beat_q       <= '0;
      stall_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      stall_q      <= stall_d;
      err_q        <= err_q | fifo_overflow_ind;
    end
  end

endmodule
